mult4x4_seg_display: RTL and testbench

//   Unsigned 4x4-bit multiplier whose 8-bit product (0..225) is converted to

---
 rtl/mult4x4_seg_display_if.sv | 24 ++
 rtl/mult4x4_seg_display.sv | 75 +++++++
 tb/tb_mult4x4_seg_display.sv | 115 +++++++++++
 3 files changed

// File: rtl/mult4x4_seg_display_if.sv
// Operand and segment-output bundle between the switch side and the display block.
interface mult4x4_seg_display_if;
    logic [3:0] A;
    logic [3:0] B;
    logic [6:0] out1;
    logic [6:0] out2;
    logic [6:0] out3;

    modport master (
        output A,
        output B,
        input  out1,
        input  out2,
        input  out3
    );

    modport slave (
        input  A,
        input  B,
        output out1,
        output out2,
        output out3
    );
endinterface

// File: rtl/mult4x4_seg_display.sv
// Unsigned 4x4 multiplier shown as three active-low 7-segment decimal digits.
// Multiply, binary-to-BCD and decode are combinational; the segment outputs are registered.
module mult4x4_seg_display (
    input  logic                         clk,
    input  logic                         rst,
    mult4x4_seg_display_if.slave         disp_if
);

    localparam logic [6:0] SegZero = 7'b1000000;

    logic [7:0]  product;
    logic [19:0] dabble;
    logic [3:0]  units, tens, hundreds;
    logic [6:0]  out1_d, out1_q;
    logic [6:0]  out2_d, out2_q;
    logic [6:0]  out3_d, out3_q;

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    assign product = 8'(disp_if.A) * 8'(disp_if.B);

    // Double-dabble: BCD digits accumulate in dabble[19:8] as the product shifts in.
    always_comb begin
        dabble = {12'd0, product};
        for (int i = 0; i < 8; i++) begin
            if (dabble[11:8] >= 4'd5)  dabble[11:8]  = dabble[11:8]  + 4'd3;
            if (dabble[15:12] >= 4'd5) dabble[15:12] = dabble[15:12] + 4'd3;
            if (dabble[19:16] >= 4'd5) dabble[19:16] = dabble[19:16] + 4'd3;
            dabble = {dabble[18:0], 1'b0};
        end
    end

    assign units    = dabble[11:8];
    assign tens     = dabble[15:12];
    assign hundreds = dabble[19:16];

    always_comb begin
        out1_d = seg7(units);
        out2_d = seg7(tens);
        out3_d = seg7(hundreds);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out1_q <= SegZero;
            out2_q <= SegZero;
            out3_q <= SegZero;
        end else begin
            out1_q <= out1_d;
            out2_q <= out2_d;
            out3_q <= out3_d;
        end
    end

    assign disp_if.out1 = out1_q;
    assign disp_if.out2 = out2_q;
    assign disp_if.out3 = out3_q;

endmodule

// File: tb/tb_mult4x4_seg_display.sv
// Directed and exhaustive check of the multiplier display against a digit/segment model.
module tb_mult4x4_seg_display;

    typedef struct {
        logic [6:0] o3;
        logic [6:0] o2;
        logic [6:0] o1;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    mult4x4_seg_display_if dif ();

    mult4x4_seg_display dut (
        .clk     (clk),
        .rst     (rst),
        .disp_if (dif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Push the model's prediction, clock once, then pop and compare.
    task automatic step(input int a, input int b, input logic r, input string tag);
        exp_t e;
        exp_t got;
        int   p;
        dif.A = 4'(a);
        dif.B = 4'(b);
        rst   = r;
        p     = a * b;
        e.tag = tag;
        if (r) begin
            e.o3 = seg_tbl[0];
            e.o2 = seg_tbl[0];
            e.o1 = seg_tbl[0];
        end else begin
            e.o3 = seg_tbl[p / 100];
            e.o2 = seg_tbl[(p / 10) % 10];
            e.o1 = seg_tbl[p % 10];
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            got = sb.pop_front();
            check({got.tag, ".out3"}, dif.out3, got.o3);
            check({got.tag, ".out2"}, dif.out2, got.o2);
            check({got.tag, ".out1"}, dif.out1, got.o1);
        end
    endtask

    initial begin
        dif.A = 4'd9;
        dif.B = 4'd9;
        rst   = 1'b1;

        step(9, 9, 1'b1, "reset_edge1");
        step(9, 9, 1'b1, "reset_edge2");
        step(9, 9, 1'b0, "release_081");
        check("081_literal_out1", dif.out1, 7'b1111001);

        step(0, 13, 1'b0, "zero_000");
        step(15, 15, 1'b0, "max_225");
        check("225_literal_out3", dif.out3, 7'b0100100);
        step(10, 10, 1'b0, "hundred_100");
        check("100_literal_out3", dif.out3, 7'b1111001);
        step(7, 9, 1'b0, "sixtythree_063");

        // Changing B must not reach the outputs before the next edge.
        dif.B = 4'd8;
        #2;
        check("hold_063.out2", dif.out2, 7'b0000010);
        check("hold_063.out1", dif.out1, 7'b0110000);
        step(7, 8, 1'b0, "fiftysix_056");

        step(15, 15, 1'b1, "reset_midop");
        step(15, 15, 1'b0, "after_midop_225");

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                step(a, b, 1'b0, $sformatf("exh_%0d_%0d", a, b));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
